// File: rtl/ram_seq_pkg.sv
// Shared types for the RAM request sequencer: controller states and arbiter grant codes.
package ram_seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/ram_req_rr_arb.sv
// Two-requester round-robin arbiter: combinational grant, registered priority pointer that
// flips only when both requesters compete in the same cycle.
module ram_req_rr_arb
  import ram_seq_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic req_wr,
  input  logic req_rd,
  output gnt_e gnt
);

  logic prio_rd_q, prio_rd_d;

  // NOTE: every signal assigned in always_comb gets a default first so no path infers a latch.
  always_comb begin
    gnt       = GNT_NONE;
    prio_rd_d = prio_rd_q;
    if (req_wr && req_rd) begin
      gnt       = prio_rd_q ? GNT_RD : GNT_WR;
      prio_rd_d = !prio_rd_q;
    end else if (req_wr) begin
      gnt = GNT_WR;
    end else if (req_rd) begin
      gnt = GNT_RD;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) prio_rd_q <= 1'b1;
    else      prio_rd_q <= prio_rd_d;
  end

endmodule

// File: rtl/ram_req_sequencer.sv
// Arbitrates write/read request streams onto a single-port RAM and returns read data.
// Optional power-up zero sweep of the RAM when RAM_SEQ_CLEAR_ON_RESET_EN is defined.
module ram_req_sequencer
  import ram_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_VALID,
  output logic                  RD_READY,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  INIT_DONE,
  output logic [DATA_WIDTH-1:0] RAM_DATA,
  output logic [ADDR_WIDTH-1:0] RAM_ADDRESS,
  output logic                  RAM_WE,
  input  logic [DATA_WIDTH-1:0] RAM_OUTPUT
);

  state_e                  state_q;
  gnt_e                    gnt;
  logic                    rd_ok;
  logic                    rd_inflight_q, rd_inflight_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;

`ifdef RAM_SEQ_CLEAR_ON_RESET_EN
  state_e                  state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == '1) state_d = ST_IDLE;
    end
  end

  assign INIT_DONE = (state_q == ST_IDLE);
`else
  assign state_q   = ST_IDLE;
  assign INIT_DONE = RST && (state_q == ST_IDLE);
`endif

  // Only one read may be outstanding: block new reads until the response is consumed.
  assign rd_ok = INIT_DONE && !rd_inflight_q && !rsp_valid_q;

  ram_req_rr_arb u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .req_wr (WR_VALID && INIT_DONE),
    .req_rd (RD_VALID && rd_ok),
    .gnt    (gnt)
  );

  assign WR_READY  = INIT_DONE && (gnt == GNT_WR);
  assign RD_READY  = (gnt == GNT_RD);
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;

  always_comb begin
    RAM_WE      = 1'b0;
    RAM_ADDRESS = last_addr_q;
    RAM_DATA    = '0;
    unique case (gnt)
      GNT_WR: begin
        RAM_WE      = 1'b1;
        RAM_ADDRESS = WR_ADDR;
        RAM_DATA    = WR_DATA;
      end
      GNT_RD:  RAM_ADDRESS = RD_ADDR;
      default: ;
    endcase
`ifdef RAM_SEQ_CLEAR_ON_RESET_EN
    if (state_q == ST_CLEAR) begin
      RAM_WE      = 1'b1;
      RAM_ADDRESS = clr_cnt_q;
      RAM_DATA    = '0;
    end
`endif
  end

  // RAM_OUTPUT is valid the cycle after the address was registered, i.e. while rd_inflight is set.
  always_comb begin
    rd_inflight_d = 1'b0;
    last_addr_d   = last_addr_q;
    rsp_valid_d   = rsp_valid_q && !RSP_READY;
    rsp_data_d    = rsp_data_q;
    if (gnt == GNT_RD) begin
      rd_inflight_d = 1'b1;
      last_addr_d   = RD_ADDR;
    end
    if (rd_inflight_q) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = RAM_OUTPUT;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_inflight_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      last_addr_q   <= '0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      last_addr_q   <= last_addr_d;
    end
  end

endmodule
